// File: rtl/hazard3_pmp_bus_filter.sv
// hazard3_pmp_bus_filter: AHB-Lite gate that blocks PMP-killed transfers and answers them with a local ERROR response.
// Optional fault address log enabled by defining HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN.
module hazard3_pmp_bus_filter #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        us_htrans,
  input  logic [W_ADDR-1:0] us_haddr,
  input  logic              us_hwrite,
  input  logic [2:0]        us_hsize,
  input  logic [3:0]        us_hprot,
  input  logic [W_DATA-1:0] us_hwdata,
  output logic              us_hready,
  output logic              us_hresp,
  output logic [W_DATA-1:0] us_hrdata,
  output logic [1:0]        ds_htrans,
  output logic [W_ADDR-1:0] ds_haddr,
  output logic              ds_hwrite,
  output logic [2:0]        ds_hsize,
  output logic [3:0]        ds_hprot,
  output logic [W_DATA-1:0] ds_hwdata,
  input  logic              ds_hready,
  input  logic              ds_hresp,
  input  logic [W_DATA-1:0] ds_hrdata,
  output logic [W_ADDR-1:0] q_addr,
  output logic              q_write,
  output logic              q_m_mode,
  input  logic              q_kill
`ifdef HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN
  ,
  output logic              fault_valid,
  output logic [W_ADDR-1:0] fault_addr,
  input  logic              fault_clr
`endif
);
  typedef enum logic [1:0] {PASS, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic kill;
  assign q_addr    = us_haddr;
  assign q_write   = us_hwrite;
  assign q_m_mode  = us_hprot[1];
  assign ds_haddr  = us_haddr;
  assign ds_hwrite = us_hwrite;
  assign ds_hsize  = us_hsize;
  assign ds_hprot  = us_hprot;
  assign ds_hwdata = us_hwdata;
  // ERR1 holds hready low, so a kill can only be accepted from PASS or ERR2
  always_comb begin
    us_hready = state_q == ERR1 ? 1'b0 : state_q == ERR2 ? 1'b1 : ds_hready;
    us_hresp  = state_q == PASS ? ds_hresp : 1'b1;
    us_hrdata = state_q == PASS ? ds_hrdata : '0;
    ds_htrans = (state_q == ERR1 || q_kill) ? 2'b00 : us_htrans;
    kill      = us_htrans[1] && us_hready && q_kill;
    state_d   = kill ? ERR1 : state_q == ERR1 ? ERR2 : PASS;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= PASS;
    else state_q <= state_d;
`ifdef HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN
  logic              fault_valid_q, fault_valid_d, capture;
  logic [W_ADDR-1:0] fault_addr_q, fault_addr_d;
  // A kill coinciding with a clear re-arms the log with the new address
  always_comb begin
    capture       = kill && (!fault_valid_q || fault_clr);
    fault_valid_d = capture ? 1'b1 : fault_clr ? 1'b0 : fault_valid_q;
    fault_addr_d  = capture ? us_haddr : fault_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
`endif
endmodule

// File: tb/tb_hazard3_pmp_bus_filter.sv
// tb_hazard3_pmp_bus_filter: vector-table bench for hazard3_pmp_bus_filter, plus reset and fault-log sequences.
module tb_hazard3_pmp_bus_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  us_htrans;
  logic [31:0] us_haddr;
  logic        us_hwrite;
  logic [2:0]  us_hsize;
  logic [3:0]  us_hprot;
  logic [31:0] us_hwdata;
  logic        us_hready, us_hresp;
  logic [31:0] us_hrdata;
  logic [1:0]  ds_htrans;
  logic [31:0] ds_haddr;
  logic        ds_hwrite;
  logic [2:0]  ds_hsize;
  logic [3:0]  ds_hprot;
  logic [31:0] ds_hwdata;
  logic        ds_hready, ds_hresp;
  logic [31:0] ds_hrdata;
  logic [31:0] q_addr;
  logic        q_write, q_m_mode, q_kill;
`ifdef HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN
  logic        fault_valid, fault_clr;
  logic [31:0] fault_addr;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hazard3_pmp_bus_filter #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .us_htrans(us_htrans), .us_haddr(us_haddr), .us_hwrite(us_hwrite), .us_hsize(us_hsize),
    .us_hprot(us_hprot), .us_hwdata(us_hwdata), .us_hready(us_hready), .us_hresp(us_hresp),
    .us_hrdata(us_hrdata),
    .ds_htrans(ds_htrans), .ds_haddr(ds_haddr), .ds_hwrite(ds_hwrite), .ds_hsize(ds_hsize),
    .ds_hprot(ds_hprot), .ds_hwdata(ds_hwdata), .ds_hready(ds_hready), .ds_hresp(ds_hresp),
    .ds_hrdata(ds_hrdata),
    .q_addr(q_addr), .q_write(q_write), .q_m_mode(q_m_mode), .q_kill(q_kill)
`ifdef HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN
    , .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_clr(fault_clr)
`endif
  );
  typedef struct {
    logic [1:0]  ht;
    logic [31:0] a;
    logic        w;
    logic [3:0]  p;
    logic        k;
    logic        dr;
    logic        de;
    logic [31:0] dd;
    logic        hr;
    logic        he;
    logic [31:0] rd;
    logic [1:0]  dt;
  } vec_t;
  vec_t tv[23];
  function automatic vec_t mk(logic [1:0] ht, logic [31:0] a, logic w, logic [3:0] p, logic k,
                              logic dr, logic de, logic [31:0] dd,
                              logic hr, logic he, logic [31:0] rd, logic [1:0] dt);
    vec_t v;
    v.ht = ht; v.a = a; v.w = w; v.p = p; v.k = k; v.dr = dr; v.de = de; v.dd = dd;
    v.hr = hr; v.he = he; v.rd = rd; v.dt = dt;
    return v;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    us_htrans = v.ht; us_haddr = v.a; us_hwrite = v.w; us_hsize = 3'd2; us_hprot = v.p;
    us_hwdata = ~v.a; q_kill = v.k; ds_hready = v.dr; ds_hresp = v.de; ds_hrdata = v.dd;
  endtask
  task automatic cyc(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
  endtask
  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d us_hready", i), 128'(us_hready), 128'(v.hr));
    chk($sformatf("v%0d us_hresp", i), 128'(us_hresp), 128'(v.he));
    chk($sformatf("v%0d us_hrdata", i), 128'(us_hrdata), 128'(v.rd));
    chk($sformatf("v%0d ds_htrans", i), 128'(ds_htrans), 128'(v.dt));
    chk($sformatf("v%0d passthrough", i),
        128'({ds_haddr, ds_hwrite, ds_hsize, ds_hprot, ds_hwdata, q_addr, q_write, q_m_mode}),
        128'({v.a, v.w, 3'd2, v.p, ~v.a, v.a, v.w, v.p[1]}));
  endtask
  initial begin
    tv[0]  = mk(2, 32'h2000_0010, 0, 4'h3, 0, 1, 0, 32'h0,         1, 0, 32'h0,         2);
    tv[1]  = mk(0, 32'h2000_0010, 0, 4'h3, 0, 0, 0, 32'hAAAA_0001, 0, 0, 32'hAAAA_0001, 0);
    tv[2]  = mk(0, 32'h2000_0010, 0, 4'h3, 0, 0, 0, 32'hAAAA_0002, 0, 0, 32'hAAAA_0002, 0);
    tv[3]  = mk(0, 32'h2000_0010, 0, 4'h3, 0, 1, 0, 32'h1234_5678, 1, 0, 32'h1234_5678, 0);
    tv[4]  = mk(2, 32'h4000_0000, 1, 4'h1, 1, 1, 0, 32'h55,        1, 0, 32'h55,        0);
    tv[5]  = mk(0, 32'h4000_0000, 1, 4'h1, 0, 1, 0, 32'hFFFF_FFFF, 0, 1, 32'h0,         0);
    tv[6]  = mk(0, 32'h4000_0000, 0, 4'h1, 0, 0, 0, 32'hFFFF_FFFF, 1, 1, 32'h0,         0);
    tv[7]  = mk(2, 32'h4000_0004, 0, 4'h1, 1, 1, 0, 32'h0,         1, 0, 32'h0,         0);
    tv[8]  = mk(2, 32'h2000_0000, 0, 4'h3, 0, 1, 0, 32'h77,        0, 1, 32'h0,         0);
    tv[9]  = mk(2, 32'h2000_0000, 0, 4'h3, 0, 1, 1, 32'h77,        1, 1, 32'h0,         2);
    tv[10] = mk(0, 32'h2000_0000, 0, 4'h3, 0, 1, 0, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, 0);
    tv[11] = mk(2, 32'h4000_0010, 1, 4'h1, 1, 1, 0, 32'h0,         1, 0, 32'h0,         0);
    tv[12] = mk(2, 32'h4000_0014, 1, 4'h1, 1, 1, 0, 32'h11,        0, 1, 32'h0,         0);
    tv[13] = mk(2, 32'h4000_0014, 1, 4'h1, 1, 1, 0, 32'h11,        1, 1, 32'h0,         0);
    tv[14] = mk(2, 32'h4000_0018, 1, 4'h1, 1, 1, 0, 32'h11,        0, 1, 32'h0,         0);
    tv[15] = mk(2, 32'h4000_0018, 1, 4'h1, 1, 1, 0, 32'h11,        1, 1, 32'h0,         0);
    tv[16] = mk(0, 32'h4000_0018, 1, 4'h1, 0, 1, 0, 32'h11,        0, 1, 32'h0,         0);
    tv[17] = mk(0, 32'h4000_0018, 1, 4'h1, 0, 1, 0, 32'h11,        1, 1, 32'h0,         0);
    tv[18] = mk(0, 32'h2000_0000, 0, 4'h3, 0, 1, 1, 32'h99,        1, 1, 32'h99,        0);
    tv[19] = mk(2, 32'h4000_0020, 0, 4'h1, 1, 1, 0, 32'h0,         1, 0, 32'h0,         0);
    tv[20] = mk(0, 32'h4000_0020, 0, 4'h1, 0, 1, 0, 32'h22,        0, 1, 32'h0,         0);
    tv[21] = mk(0, 32'h4000_0020, 0, 4'h1, 0, 1, 0, 32'h22,        1, 1, 32'h0,         0);
    tv[22] = mk(0, 32'h2000_0000, 0, 4'h3, 0, 0, 0, 32'h33,        0, 0, 32'h33,        0);
`ifdef HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN
    fault_clr = 1'b0;
`endif
    drive(mk(0, 32'h0, 0, 4'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0));
    @(negedge clk);
    chk("reset us_hready", 128'(us_hready), 128'(1'b1));
    chk("reset us_hresp", 128'(us_hresp), 128'(1'b0));
    chk("reset ds_htrans", 128'(ds_htrans), 128'(2'b00));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      cyc(tv[i]);
      check_vec(i, tv[i]);
    end
`ifdef HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN
    chk("log first kill valid", 128'(fault_valid), 128'(1'b1));
    chk("log first kill addr", 128'(fault_addr), 128'(32'h4000_0000));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("log reset valid", 128'(fault_valid), 128'(1'b0));
    chk("log reset addr", 128'(fault_addr), 128'(32'h0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(mk(2, 32'h100, 1, 4'h1, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 32'h100, 1, 4'h1, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("log 0x100 valid", 128'(fault_valid), 128'(1'b1));
    chk("log 0x100 addr", 128'(fault_addr), 128'(32'h100));
    cyc(mk(2, 32'h200, 1, 4'h1, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 32'h200, 1, 4'h1, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("log keeps 0x100", 128'(fault_addr), 128'(32'h100));
    @(posedge clk);
    #1;
    drive(mk(2, 32'h300, 1, 4'h1, 1, 1, 0, 0, 0, 0, 0, 0));
    fault_clr = 1'b1;
    cyc(mk(0, 32'h300, 1, 4'h1, 0, 1, 0, 0, 0, 0, 0, 0));
    fault_clr = 1'b0;
    chk("log clr+kill valid", 128'(fault_valid), 128'(1'b1));
    chk("log clr+kill addr", 128'(fault_addr), 128'(32'h300));
    @(posedge clk);
    #1;
    drive(mk(0, 32'h0, 0, 4'h1, 0, 1, 0, 0, 0, 0, 0, 0));
    fault_clr = 1'b1;
    @(posedge clk);
    #1 fault_clr = 1'b0;
    @(negedge clk);
    chk("log clr valid", 128'(fault_valid), 128'(1'b0));
`endif
    cyc(mk(2, 32'h4000_0040, 0, 4'h1, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 32'h4000_0040, 0, 4'h1, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("pre-reset in ERR1 us_hready", 128'(us_hready), 128'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("mid-ERR1 reset us_hready", 128'(us_hready), 128'(1'b1));
    chk("mid-ERR1 reset us_hresp", 128'(us_hresp), 128'(1'b0));
    chk("mid-ERR1 reset ds_htrans", 128'(ds_htrans), 128'(2'b00));
`ifdef HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN
    chk("mid-ERR1 reset fault_valid", 128'(fault_valid), 128'(1'b0));
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(mk(0, 32'h0, 0, 4'h3, 0, 0, 0, 32'h44, 0, 0, 0, 0));
    chk("post-reset PASS us_hready", 128'(us_hready), 128'(1'b0));
    chk("post-reset PASS us_hrdata", 128'(us_hrdata), 128'(32'h44));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard3_pmp_bus_filter.md
Name: hazard3_pmp_bus_filter

Overview:
AHB-Lite gate that sits between the core's load/store master port (upstream) and the system bus (downstream).
- Each upstream address phase is presented to the hazard3_pmp data query port (d_addr/d_m_mode/d_write → d_kill).
- Permitted transfers pass through unchanged.
- Killed transfers never reach the downstream bus; the block answers them with a locally generated two-cycle AHB ERROR response.
- Use: bus-side PMP enforcement for masters without in-core PMP, e.g. a debug or DMA master on the same fabric.

Parameters:
W_ADDR, 32, address width (bits)
W_DATA, 32, data width (bits)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Upstream (from master):
us_htrans  in  2  transfer type (only bit 1 significant: NONSEQ vs IDLE)
us_haddr  in  W_ADDR  address
us_hwrite  in  1  write
us_hsize  in  3  size
us_hprot  in  4  protection; bit 1 = privileged (M-mode)
us_hwdata  in  W_DATA  write data
us_hready  out  1  transfer done
us_hresp  out  1  error response
us_hrdata  out  W_DATA  read data
Downstream (to bus):
ds_htrans  out  2  transfer type
ds_haddr  out  W_ADDR  address
ds_hwrite  out  1  write
ds_hsize  out  3  size
ds_hprot  out  4  protection
ds_hwdata  out  W_DATA  write data
ds_hready  in  1  downstream ready
ds_hresp  in  1  downstream error
ds_hrdata  in  W_DATA  downstream read data
PMP query:
q_addr  out  W_ADDR  = us_haddr (combinational)
q_write  out  1  = us_hwrite
q_m_mode  out  1  = us_hprot[1]
q_kill  in  1  combinational kill result for current query

Behaviour:
- Reset is one clock, asynchronous, active-low (clk / rst_n).
- Reset state: PASS. At reset, us_hready=1, us_hresp=0, ds_htrans=IDLE.
- Address-phase acceptance: us_htrans[1] && us_hready.
- Kill: an accepted transfer with q_kill=1.
- States: PASS, ERR1, ERR2. Registered state only; no address/data buffering.
- PASS:
  - us_hready=ds_hready, us_hresp=ds_hresp, us_hrdata=ds_hrdata.
  - ds_htrans = q_kill ? IDLE : us_htrans.
  - On an accepted kill → ERR1 (the killed transfer's data phase).
  - Otherwise stay in PASS.
- ERR1:
  - us_hready=0, us_hresp=1. ds_htrans forced IDLE.
  - A master change of htrans (e.g. cancel to IDLE) is legal here and is not accepted.
  - Unconditionally → ERR2.
- ERR2:
  - us_hready=1, us_hresp=1.
  - ds_htrans = q_kill ? IDLE : us_htrans (new address phase forwarded; downstream is idle, so ds_hready is already high).
  - Accepted kill → ERR1. Else → PASS.
- us_hrdata in ERR1/ERR2: all zeros.
- ds_haddr/hwrite/hsize/hprot are always combinational passthrough of upstream. ds_hwdata is always passthrough.
- ds_hready and ds_hresp are ignored outside PASS; no downstream data phase exists then.
- Back-to-back kills: ERR1, ERR2, ERR1, ERR2… with no PASS cycle between.
- Kill accepted while a forwarded transfer's data phase is stalled: impossible, since acceptance requires us_hready=ds_hready=1.
- Reset mid-ERR: immediately returns to PASS. The upstream master is reset on the same rst_n.
- Latency:
  - Zero added cycles for permitted transfers (purely combinational path in PASS).
  - Exactly 2 data-phase cycles for killed transfers.

Optional Feature:
Macro HAZARD3_PMP_BUS_FILTER_FAULT_LOG_EN.
- Defined, adds three ports:
  - fault_valid out 1
  - fault_addr out W_ADDR
  - fault_clr in 1
- On the first accepted kill while fault_valid=0, the block registers us_haddr into fault_addr and sets fault_valid.
- Later kills do not overwrite the log.
- fault_clr=1 clears fault_valid next cycle. A simultaneous kill and clr re-captures the new address and keeps fault_valid=1.
- Reset: fault_valid=0, fault_addr=0.
- Undefined: the ports and registers are absent; the rest of the behaviour is identical.

Test Plan:
1. Permitted read, q_kill=0, haddr=0x2000_0010, ds_hready low 2 cycles → ds_htrans=NONSEQ that cycle; us_hready mirrors ds_hready; us_hrdata=ds_hrdata; us_hresp=0.
2. Killed write, q_kill=1, haddr=0x4000_0000 → ds_htrans=IDLE; next cycle us_hready=0/us_hresp=1; following cycle us_hready=1/us_hresp=1; downstream never sees NONSEQ.
3. Kill followed in ERR2 by a permitted NONSEQ to 0x2000_0000 → ds_htrans=NONSEQ in the ERR2 cycle; state → PASS; normal data phase follows.
4. Three consecutive killed transfers → us_hresp=1 for 6 cycles, us_hready pattern 0,1,0,1,0,1.
5. Master drives htrans=IDLE in ERR1 → not accepted, ds_htrans stays IDLE; ERR2 completes; state PASS.
6. FAULT_LOG_EN: kills to 0x100 then 0x200 → fault_addr=0x100; fault_clr pulse coincident with kill to 0x300 → fault_addr=0x300, fault_valid=1; rst_n low mid-ERR1 → PASS, us_hready=1, fault_valid=0.
